// File: rtl/isa_pkg.sv
// Instruction-set types and decode helpers shared by the program sequencer
// and its return stack.
package isa_pkg;

    localparam int pc_length            = 12;
    localparam int instruction_length   = 16;
    localparam int value_length         = 32;
    localparam int stack_pointer_length = 5;
    localparam int relative_length      = 8;

    typedef logic [pc_length-1:0]          pc_t;
    typedef logic [instruction_length-1:0] instruction_t;
    typedef logic [value_length-1:0]       value_t;
    typedef logic [3:0]                    opcode_t;
    typedef logic [3:0]                    register_index_t;
    typedef logic [relative_length-1:0]    relative_branch_address_t;

    // Branch opcodes resolved inside the sequencer; everything else is forwarded.
    localparam opcode_t OP_JUMP = 4'hC;
    localparam opcode_t OP_CALL = 4'hD;
    localparam opcode_t OP_RET  = 4'hE;
    localparam opcode_t OP_UNL  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COND
    } seq_state_t;

    function automatic opcode_t get_opcode(instruction_t word);
        return word[15:12];
    endfunction

    function automatic pc_t get_jump_address(instruction_t word);
        return word[pc_length-1:0];
    endfunction

    function automatic register_index_t get_cond_register(instruction_t word);
        return word[11:8];
    endfunction

    function automatic relative_branch_address_t get_relative_address(instruction_t word);
        return word[relative_length-1:0];
    endfunction

    // Sign-extends the 8-bit offset and adds it to the fall-through PC; the
    // sum wraps silently at 12 bits.
    function automatic pc_t branch_target(pc_t next_pc, relative_branch_address_t offset);
        pc_t extended;
        extended = {{(pc_length-relative_length){offset[relative_length-1]}}, offset};
        return next_pc + extended;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for CALL/RET. Only the occupancy count is reset;
// entry contents are don't-care until written.
module return_stack
    import isa_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  pc_t  push_data,
    output pc_t  top,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    pc_t            entries [DEPTH];
    logic [AW:0]    count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // With count==DEPTH the low bits wrap to 0, so minus one still selects the last entry.
    assign top   = entries[count[AW-1:0] - AW'(1)];

    // Occupancy counter: cleared by reset or a new kernel start, pushes and pops are guarded.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + (AW+1)'(1);
        end else if (pop && !empty) begin
            count <= count - (AW+1)'(1);
        end
    end

    // Entry storage: written at the current count on every accepted push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[count[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/branch controller for one cellular-automaton core. Drives the PC into
// a synchronous instruction memory, resolves JUMP/CALL/RET/UNL locally and
// forwards every other instruction over a valid/ready handshake.
module program_sequencer
    import isa_pkg::*;
#(
    parameter pc_t ENTRY_PC    = 12'h000,
    parameter int  STACK_DEPTH = 2**stack_pointer_length
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        stack_fault,
    output logic        imem_en,
    output logic [11:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [11:0] instr_pc,
    output logic        cond_req,
    output logic [3:0]  cond_reg,
    input  logic        cond_valid,
    input  logic [31:0] cond_value
);

    seq_state_t state, state_n;
    pc_t        pc, pc_n;
    pc_t        dpc, dpc_n;
    logic       dvalid, dvalid_n;
    logic       done_n;
    logic       fetch;
    logic       push, pop, stack_clear;
    logic       fault_set, fault_clear;
    pc_t        stack_top;
    logic       stack_full, stack_empty;
    pc_t        next_seq_pc;
    opcode_t    opcode;

    // The memory holds its output while imem_en is low, so imem_data doubles
    // as the instruction register during stalls and condition waits.
    assign opcode      = get_opcode(imem_data);
    assign next_seq_pc = dpc + pc_t'(1);
    assign imem_addr   = pc;
    assign instr       = imem_data;
    assign instr_pc    = dpc;
    assign cond_reg    = get_cond_register(imem_data);
    assign busy        = (state != IDLE);

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (stack_clear),
        .push      (push),
        .pop       (pop),
        .push_data (next_seq_pc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // State, PC pipeline, done pulse and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= ENTRY_PC;
            dpc         <= ENTRY_PC;
            dvalid      <= 1'b0;
            done        <= 1'b0;
            stack_fault <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            dpc    <= dpc_n;
            dvalid <= dvalid_n;
            done   <= done_n;
            if (fault_set) begin
                stack_fault <= 1'b1;
            end else if (fault_clear) begin
                stack_fault <= 1'b0;
            end
        end
    end

    // Next-state, decode and handshake outputs; a redirect leaves the fetch idle for one cycle.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        dpc_n       = dpc;
        dvalid_n    = dvalid;
        done_n      = 1'b0;
        fetch       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        stack_clear = 1'b0;
        fault_set   = 1'b0;
        fault_clear = 1'b0;
        imem_en     = 1'b0;
        instr_valid = 1'b0;
        cond_req    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    pc_n        = ENTRY_PC;
                    dvalid_n    = 1'b0;
                    stack_clear = 1'b1;
                    fault_clear = 1'b1;
                    state_n     = RUN;
                end
            end

            RUN: begin
                if (!dvalid) begin
                    fetch = 1'b1;
                end else begin
                    case (opcode)
                        OP_JUMP: begin
                            pc_n     = get_jump_address(imem_data);
                            dvalid_n = 1'b0;
                        end
                        OP_CALL: begin
                            dvalid_n = 1'b0;
                            if (stack_full) begin
                                fault_set = 1'b1;
                                state_n   = IDLE;
                            end else begin
                                push = 1'b1;
                                pc_n = get_jump_address(imem_data);
                            end
                        end
                        OP_RET: begin
                            dvalid_n = 1'b0;
                            if (stack_empty) begin
                                done_n  = 1'b1;
                                state_n = IDLE;
                            end else begin
                                pop  = 1'b1;
                                pc_n = stack_top;
                            end
                        end
                        OP_UNL: begin
                            state_n = COND;
                        end
                        default: begin
                            instr_valid = 1'b1;
                            fetch       = instr_ready;
                        end
                    endcase
                end

                if (fetch) begin
                    imem_en  = 1'b1;
                    dpc_n    = pc;
                    dvalid_n = 1'b1;
                    pc_n     = pc + pc_t'(1);
                end
            end

            COND: begin
                cond_req = 1'b1;
                if (cond_valid) begin
                    if (cond_value == '0) begin
                        pc_n = branch_target(next_seq_pc, get_relative_address(imem_data));
                    end else begin
                        pc_n = next_seq_pc;
                    end
                    dvalid_n = 1'b0;
                    state_n  = RUN;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a behavioural synchronous instruction
// memory, a ready/condition responder and hand-computed expected traces.
module tb_program_sequencer;

    localparam logic [15:0] ADD = 16'h1000;
    localparam logic [15:0] RET = 16'hE000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, stack_fault, imem_en;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        cond_req;
    logic [3:0]  cond_reg;
    logic        cond_valid = 1'b0;
    logic [31:0] cond_value = '0;

    logic [15:0] mem [0:4095];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [11:0] acc_pc [$];
    int          acc_cyc [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stall_left = 0;
    logic [11:0] stall_pc = '0;
    logic [15:0] stall_word = '0;
    int          cond_delay = 3;
    int          cond_cnt = 0;
    logic [31:0] cond_set = '0;
    int          cond_seen = 0;
    logic [3:0]  seen_cond_reg = '0;

    program_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .stack_fault (stack_fault),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .cond_req    (cond_req),
        .cond_reg    (cond_reg),
        .cond_valid  (cond_valid),
        .cond_value  (cond_value)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory that holds its output while not enabled.
    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    // Free-running cycle count used to measure issue spacing.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives ready/condition responses on the falling edge, then logs what the DUT presents.
    always @(negedge clk) begin
        if (stall_left > 0 && instr_valid && instr_pc == stall_pc) instr_ready = 1'b0;
        else instr_ready = 1'b1;
        if (cond_req) begin
            cond_cnt++;
            cond_valid = (cond_cnt == cond_delay);
        end else begin
            cond_cnt = 0;
            cond_valid = 1'b0;
        end
        cond_value = cond_set;
        #1;
        if (instr_valid && instr_ready) begin
            acc_pc.push_back(instr_pc);
            acc_cyc.push_back(cyc);
        end
        if (instr_valid && !instr_ready) begin
            checkOutput("stall_pc", 32'(instr_pc), 32'(stall_pc));
            checkOutput("stall_word", 32'(instr), 32'(stall_word));
            checkOutput("stall_imem_en", 32'(imem_en), 32'd0);
            stall_left--;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cond_req) begin
            cond_seen++;
            seen_cond_reg = cond_reg;
        end
    end

    function automatic logic [31:0] pcAt(int i);
        return (i < acc_pc.size()) ? 32'(acc_pc[i]) : 32'hDEADBEEF;
    endfunction

    function automatic int cycAt(int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -100000;
    endfunction

    task automatic clearMem();
        for (int i = 0; i < 4096; i++) mem[i] = RET;
    endtask

    task automatic loadStraight();
        clearMem();
        for (int i = 0; i < 4; i++) mem[i] = ADD | 16'(i);
        mem[4] = RET;
    endtask

    // Starts one kernel run and waits (bounded) for busy to fall.
    task automatic applyStimulus(input int budget);
        int n;
        n = 0;
        acc_pc.delete();
        acc_cyc.delete();
        done_cnt = 0;
        cond_seen = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #2;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("fault_cleared_by_start", 32'(stack_fault), 32'd0);
        while (busy && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        checkOutput("run_finished", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_fault", 32'(stack_fault), 32'd0);
        checkOutput("rst_imem_en", 32'(imem_en), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_cond_req", 32'(cond_req), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Straight line: 0..3 issue back to back, done two cycles after pc 3.
        loadStraight();
        applyStimulus(50);
        checkOutput("line_count", 32'(acc_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("line_pc", pcAt(i), 32'(i));
            checkOutput("line_spacing", 32'(cycAt(i) - cycAt(0)), 32'(i));
        end
        checkOutput("line_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("line_done_delay", 32'(done_cyc - cycAt(3)), 32'd2);

        // Backpressure: three refused presentations of pc 1, then no loss or duplicate.
        loadStraight();
        stall_pc = 12'h001;
        stall_word = 16'h1001;
        stall_left = 3;
        applyStimulus(50);
        checkOutput("bp_count", 32'(acc_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("bp_pc", pcAt(i), 32'(i));
        checkOutput("bp_gap_stall", 32'(cycAt(1) - cycAt(0)), 32'd4);
        checkOutput("bp_gap_resume", 32'(cycAt(2) - cycAt(1)), 32'd1);
        checkOutput("bp_stalls_seen", 32'(stall_left), 32'd0);

        // JUMP 0x100 at 0x005: the word at 0x006 never issues, one idle fetch cycle.
        clearMem();
        for (int i = 0; i < 5; i++) mem[i] = ADD | 16'(i);
        mem[5] = 16'hC100;
        mem[6] = 16'h1006;
        mem[12'h100] = 16'h1100;
        mem[12'h101] = RET;
        applyStimulus(50);
        checkOutput("jump_count", 32'(acc_pc.size()), 32'd6);
        checkOutput("jump_pc_before", pcAt(4), 32'h004);
        checkOutput("jump_pc_target", pcAt(5), 32'h100);
        checkOutput("jump_gap", 32'(cycAt(5) - cycAt(4)), 32'd3);

        // CALL 0x020 at 0x010 returning to 0x011.
        clearMem();
        mem[12'h000] = 16'hC010;
        mem[12'h010] = 16'hD020;
        mem[12'h020] = RET;
        mem[12'h011] = 16'h1011;
        mem[12'h012] = RET;
        applyStimulus(50);
        checkOutput("call_count", 32'(acc_pc.size()), 32'd1);
        checkOutput("call_return_pc", pcAt(0), 32'h011);
        checkOutput("call_done_cnt", 32'(done_cnt), 32'd1);

        // 32 nested CALLs unwound by RETs: no fault, single done.
        clearMem();
        for (int k = 0; k < 32; k++) mem[2*k] = 16'hD000 | 16'(2*k + 2);
        applyStimulus(600);
        checkOutput("nest32_fault", 32'(stack_fault), 32'd0);
        checkOutput("nest32_done_cnt", 32'(done_cnt), 32'd1);

        // A 33rd CALL overflows: sticky fault, busy drops, no done.
        mem[64] = 16'hD042;
        applyStimulus(600);
        checkOutput("nest33_fault", 32'(stack_fault), 32'd1);
        checkOutput("nest33_busy", 32'(busy), 32'd0);
        checkOutput("nest33_done_cnt", 32'(done_cnt), 32'd0);

        // UNL r3,-4 at 0x040 taken on a zero condition.
        clearMem();
        mem[12'h000] = 16'hC040;
        mem[12'h040] = 16'hF3FC;
        mem[12'h03D] = 16'h103D;
        mem[12'h03E] = RET;
        mem[12'h041] = 16'h1041;
        mem[12'h042] = RET;
        cond_delay = 3;
        cond_set = 32'd0;
        applyStimulus(60);
        checkOutput("unl_taken_pc", pcAt(0), 32'h03D);
        checkOutput("unl_taken_count", 32'(acc_pc.size()), 32'd1);
        checkOutput("unl_cond_reg", 32'(seen_cond_reg), 32'd3);
        checkOutput("unl_taken_done", 32'(done_cnt), 32'd1);

        // Same UNL falls through on a non-zero condition.
        cond_set = 32'd7;
        applyStimulus(60);
        checkOutput("unl_not_taken_pc", pcAt(0), 32'h041);
        checkOutput("unl_not_taken_count", 32'(acc_pc.size()), 32'd1);

        // UNL +1 at 0xFFF wraps to 0x001.
        clearMem();
        mem[12'h000] = 16'hCFFF;
        mem[12'hFFF] = 16'hF001;
        mem[12'h001] = 16'h1001;
        mem[12'h002] = RET;
        cond_set = 32'd0;
        applyStimulus(60);
        checkOutput("unl_wrap_pc", pcAt(0), 32'h001);

        // Reset while waiting on a condition that never arrives, then restart.
        clearMem();
        mem[12'h000] = 16'hC040;
        mem[12'h040] = 16'hF3FC;
        cond_delay = 1000;
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!cond_req && n < 30) begin
            @(negedge clk); #2;
            n++;
        end
        checkOutput("rst_cond_reached", 32'(cond_req), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #2;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_cond_req", 32'(cond_req), 32'd0);
        checkOutput("midrst_instr_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk); #2;
        checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
        loadStraight();
        cond_delay = 3;
        applyStimulus(50);
        checkOutput("restart_first_pc", pcAt(0), 32'h000);
        checkOutput("restart_count", 32'(acc_pc.size()), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
